// File: rtl/pattern_matcher_if.sv
// Avalon-ST sink/source bundle for pattern_matcher.
// slave is the matcher side, master is the producer/consumer side.
interface pattern_matcher_if #(
  parameter int SYM_W = 8
);
  logic [SYM_W-1:0] snk_data_i;
  logic             snk_valid_i;
  logic             snk_sop_i;
  logic             snk_eop_i;
  logic             snk_ready_o;
  logic [SYM_W-1:0] src_data_o;
  logic             src_valid_o;
  logic             src_sop_o;
  logic             src_eop_o;
  logic             src_match_o;
  logic             src_ready_i;

  modport slave (
    input  snk_data_i, snk_valid_i,
    input  snk_sop_i, snk_eop_i,
    input  src_ready_i,
    output snk_ready_o,
    output src_data_o, src_valid_o,
    output src_sop_o, src_eop_o,
    output src_match_o
  );

  modport master (
    output snk_data_i, snk_valid_i,
    output snk_sop_i, snk_eop_i,
    output src_ready_i,
    input  snk_ready_o,
    input  src_data_o, src_valid_o,
    input  src_sop_o, src_eop_o,
    input  src_match_o
  );
endinterface

// File: rtl/pattern_matcher.sv
// Streaming key-pattern detector with one-stage forwarding and eop match tag.
// Define PATTERN_MATCHER_CNT_EN to build the matched-packet counter.
module pattern_matcher #(
  parameter int SYM_W    = 8,
  parameter int PAT_SYMS = 12,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic [0:PAT_SYMS*SYM_W-1]   pattern_i,
  input  logic                        enable_i,
  pattern_matcher_if.slave            st,
  output logic [CNT_W-1:0]            match_cnt_o
);

  localparam int PW = PAT_SYMS * SYM_W;
  localparam int HW = (PAT_SYMS - 1) * SYM_W;
  localparam int FW = $clog2(PAT_SYMS);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_SYMS - 1);

  typedef enum logic {IDLE, PKT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pat_q, pat_d;
  logic             en_q, en_d;
  logic             sticky_q, sticky_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [SYM_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             match_q, match_d;

  logic acc;
  logic hit;
  logic fwd;
  logic mflag;

  assign st.snk_ready_o = st.src_ready_i | ~valid_q;
  assign acc = st.snk_valid_i & st.snk_ready_o;

  // window = oldest history symbol first, matching pattern symbol 0 first
  assign hit = en_q && (fill_q == FILL_MAX) &&
               ({hist_q, st.snk_data_i} == pat_q);

  assign st.src_data_o  = data_q;
  assign st.src_valid_o = valid_q;
  assign st.src_sop_o   = sop_q;
  assign st.src_eop_o   = eop_q;
  assign st.src_match_o = match_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    en_d     = en_q;
    sticky_d = sticky_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    match_d  = match_q;
    fwd      = 1'b0;
    mflag    = 1'b0;

    if (st.snk_ready_o) valid_d = 1'b0;

    if (acc) begin
      unique case (1'b1)
        st.snk_sop_i: begin
          pat_d    = pattern_i;
          en_d     = enable_i;
          hist_d   = HW'(st.snk_data_i);
          fill_d   = FW'(1);
          sticky_d = 1'b0;
          state_d  = st.snk_eop_i ? IDLE : PKT;
          fwd      = 1'b1;
        end
        (!st.snk_sop_i && state_q == PKT): begin
          hist_d   = {hist_q[HW-SYM_W-1:0], st.snk_data_i};
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
          sticky_d = sticky_q | hit;
          mflag    = sticky_q | hit;
          if (st.snk_eop_i) state_d = IDLE;
          fwd      = 1'b1;
        end
        default: ;
      endcase
    end

    if (fwd) begin
      valid_d = 1'b1;
      data_d  = st.snk_data_i;
      sop_d   = st.snk_sop_i;
      eop_d   = st.snk_eop_i;
      match_d = st.snk_eop_i & mflag;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pat_q    <= '0;
      en_q     <= 1'b0;
      sticky_q <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      en_q     <= en_d;
      sticky_q <= sticky_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      match_q  <= match_d;
    end
  end

`ifdef PATTERN_MATCHER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else if (valid_q & st.src_ready_i & eop_q & match_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt_o = cnt_q;
`else
  assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed + randomized bench for pattern_matcher.
// Reference model: substring search over each whole packet.
module tb_pattern_matcher;
  localparam int SYM_W = 8;
  localparam int PAT_SYMS = 12;
  localparam int CNT_W = 16;
  localparam int PW = PAT_SYMS * SYM_W;
`ifdef PATTERN_MATCHER_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:PW-1] pattern;
  logic enable;
  logic [CNT_W-1:0] match_cnt;

  pattern_matcher_if #(.SYM_W(SYM_W)) bus();

  pattern_matcher #(
    .SYM_W(SYM_W), .PAT_SYMS(PAT_SYMS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .arst_n_i(rst_n),
    .pattern_i(pattern),
    .enable_i(enable),
    .st(bus),
    .match_cnt_o(match_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit in_rst = 1'b1;
  bit rnd_ready = 1'b0;
  logic [10:0] exp_q[$];
  int exp_cnt = 0;
  int nbeats = 0;
  logic last_match = 1'b0;

  bit m_in_pkt = 1'b0;
  bit m_en = 1'b0;
  logic [PW-1:0] m_pat = '0;
  byte unsigned m_pkt[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit contains();
    for (int s = 0; s + PAT_SYMS <= m_pkt.size(); s++) begin
      bit ok = 1'b1;
      for (int k = 0; k < PAT_SYMS; k++)
        if (m_pkt[s+k] != m_pat[PW-1-SYM_W*k -: SYM_W]) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic model_accept(input byte unsigned d, input bit s,
                              input bit e);
    if (s) begin
      m_en = enable;
      m_pat = pattern;
      m_pkt.delete();
      m_pkt.push_back(d);
      m_in_pkt = !e;
      exp_q.push_back({d, 1'b1, e, e && m_en && contains()});
    end else if (m_in_pkt) begin
      m_pkt.push_back(d);
      exp_q.push_back({d, 1'b0, e, e && m_en && contains()});
      if (e) m_in_pkt = 1'b0;
    end
  endtask

  // called exactly at a falling edge
  task automatic send_beat(input byte unsigned d, input bit s,
                           input bit e);
    int budget = 0;
    bus.snk_data_i = d;
    bus.snk_sop_i = s;
    bus.snk_eop_i = e;
    bus.snk_valid_i = 1'b1;
    #1;
    while (!bus.snk_ready_o && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("accept_timeout", 32'(budget < 200), 32'd1);
    model_accept(d, s, e);
    @(negedge clk);
    bus.snk_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input bq_t q);
    @(negedge clk);
    for (int i = 0; i < q.size(); i++)
      send_beat(q[i], i == 0, i == q.size() - 1);
  endtask

  task automatic drain();
    int b = 0;
    rnd_ready = 1'b0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      #2;
      b++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2;
  endtask

  always @(negedge clk)
    bus.src_ready_i = rnd_ready ? 1'($urandom % 2) : 1'b1;

  logic [10:0] stall_v;
  bit stall_p = 1'b0;
  logic [10:0] obs_b;
  logic [10:0] e_b;

  always begin
    @(negedge clk);
    #1;
    if (in_rst) begin
      stall_p = 1'b0;
    end else begin
      obs_b = {bus.src_data_o, bus.src_sop_o, bus.src_eop_o,
               bus.src_match_o};
      chk("match_cnt", 32'(match_cnt), 32'(exp_cnt));
      if (stall_p) chk("stall_stable", 32'(obs_b), 32'(stall_v));
      stall_p = 1'b0;
      if (bus.src_valid_o && bus.src_ready_i) begin
        chk("unexpected_beat", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_b = exp_q.pop_front();
          chk("beat", 32'(obs_b), 32'(e_b));
          nbeats++;
          if (e_b[1]) begin
            last_match = bus.src_match_o;
            if (e_b[0]) exp_cnt += CE;
          end
        end
      end else if (bus.src_valid_o) begin
        stall_p = 1'b1;
        stall_v = obs_b;
      end
    end
  end

  bq_t q;
  int nb0;
  int total;
  int len;
  int pos;

  initial begin
    pattern = "ABCDEFGHIJKL";
    enable = 1'b1;
    bus.snk_data_i = '0;
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i = 1'b0;
    bus.snk_eop_i = 1'b0;

    // reset values
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.src_valid_o), 32'd0);
    chk("rst_data", 32'(bus.src_data_o), 32'd0);
    chk("rst_flags", 32'({bus.src_sop_o, bus.src_eop_o,
        bus.src_match_o}), 32'd0);
    chk("rst_ready", 32'(bus.snk_ready_o), 32'd1);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_rst = 1'b0;

    // pattern in the middle of a 20-byte packet
    nb0 = nbeats;
    send_pkt(s2q("xxABCDEFGHIJKLxxxxxx"));
    drain();
    chk("t1_match", 32'(last_match), 32'd1);
    chk("t1_beats", 32'(nbeats - nb0), 32'd20);
    chk("t1_cnt", 32'(match_cnt), 32'(CE * 1));

    // exact-length and one-short packets
    send_pkt(s2q("ABCDEFGHIJKL"));
    drain();
    chk("t2_exact", 32'(last_match), 32'd1);
    send_pkt(s2q("ABCDEFGHIJK"));
    drain();
    chk("t2_short", 32'(last_match), 32'd0);
    chk("t2_cnt", 32'(match_cnt), 32'(CE * 2));

    // pattern split across two packets
    send_pkt(s2q("qqqqABCDEF"));
    drain();
    chk("t3_first", 32'(last_match), 32'd0);
    send_pkt(s2q("GHIJKLqqq"));
    drain();
    chk("t3_second", 32'(last_match), 32'd0);
    chk("t3_cnt", 32'(match_cnt), 32'(CE * 2));

    // enable raised mid-packet has no effect
    q = s2q("ABCDEFGHIJKLzz");
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 3) enable = 1'b1;
      send_beat(q[i], i == 0, i == q.size() - 1);
    end
    drain();
    chk("t4_disabled", 32'(last_match), 32'd0);

    // pattern changed mid-packet has no effect either
    q = s2q("qABCDEFGHIJKL");
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 2) pattern = "zzzzzzzzzzzz";
      send_beat(q[i], i == 0, i == q.size() - 1);
    end
    pattern = "ABCDEFGHIJKL";
    drain();
    chk("t4_enabled", 32'(last_match), 32'd1);
    chk("t4_cnt", 32'(match_cnt), 32'(CE * 3));

    // random backpressure, 100 packets
    nb0 = nbeats;
    total = 0;
    rnd_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 30);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back(8'($urandom_range(8'h41, 8'h4c)));
      if (len >= PAT_SYMS && ($urandom % 2) == 1) begin
        pos = $urandom_range(0, len - PAT_SYMS);
        for (int k = 0; k < PAT_SYMS; k++)
          q[pos+k] = pattern[SYM_W*k +: SYM_W];
      end
      enable = ($urandom % 4) != 0;
      total += len;
      rnd_ready = 1'b1;
      send_pkt(q);
    end
    enable = 1'b1;
    drain();
    chk("rand_beats", 32'(nbeats - nb0), 32'(total));

    // reset mid-packet with a beat in flight
    q = s2q("ABCDEFGHIJKLmnop");
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_beat(q[i], i == 0, 1'b0);
    rst_n = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    m_in_pkt = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_rst_valid", 32'(bus.src_valid_o), 32'd0);
      chk("mid_rst_data", 32'(bus.src_data_o), 32'd0);
      chk("mid_rst_ready", 32'(bus.snk_ready_o), 32'd1);
      chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_rst = 1'b0;

    // stray beats, then a clean packet
    nb0 = nbeats;
    send_beat(8'h47, 1'b0, 1'b0);
    send_beat(8'h48, 1'b0, 1'b0);
    send_beat(8'h49, 1'b0, 1'b1);
    send_pkt(s2q("zABCDEFGHIJKL"));
    drain();
    chk("post_rst_beats", 32'(nbeats - nb0), 32'd13);
    chk("post_rst_match", 32'(last_match), 32'd1);
    chk("post_rst_cnt", 32'(match_cnt), 32'(CE * 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
